rf_wb_scoreboard: RTL and testbench

- Scoreboard and write-port arbiter for the 32x32 register file (RF) in the RV32I pipeline.
- Tracks destination registers of in-flight long-latency ops (load miss, mul/div) and stalls issue on RAW/WAW hazards against them.
- Arbitrates the RF's single write port between the in-order pipeline writeback and the long-latency return path.
- Drives the RF write controls (RFWr, A3, WD) directly.

---
 rtl/rf_wb_scoreboard.sv | 108 ++++++++++
 tb/tb_rf_wb_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_scoreboard.sv
// Register-file write-port arbiter and long-latency destination scoreboard.
// Pipeline writeback wins the port; issue stalls on RAW/WAW, capacity or long-write starvation.
module rf_wb_scoreboard #(
   parameter int MAX_OUT    = 4,
   parameter int STARVE_LIM = 8,
   localparam int OW = $clog2(MAX_OUT + 1),
   localparam int SW = $clog2(STARVE_LIM + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iss_valid,
   input  logic [4:0]    iss_rs1,
   input  logic [4:0]    iss_rs2,
   input  logic          iss_use1,
   input  logic          iss_use2,
   input  logic [4:0]    iss_rd,
   input  logic          iss_wr,
   input  logic          iss_long,
   output logic          iss_stall,
   input  logic          p_wr,
   input  logic [4:0]    p_rd,
   input  logic [31:0]   p_wd,
   input  logic          l_valid,
   input  logic [4:0]    l_rd,
   input  logic [31:0]   l_wd,
   output logic          l_ready,
   output logic          RFWr,
   output logic [4:0]    A3,
   output logic [31:0]   WD,
   output logic [31:0]   pend,
   output logic [OW-1:0] outstanding
);

   logic [31:0]   pend_q, pend_d;
   logic [OW-1:0] out_q, out_d;
   logic [SW-1:0] starve_q, starve_d;

   logic long_grant;
   logic long_acc;
   logic hazard_raw;
   logic hazard_waw;
   logic cap_full;
   logic starved;

   assign l_ready    = l_valid & ~p_wr;
   assign long_grant = l_ready;

   always_comb begin
      RFWr = 1'b0;
      A3   = '0;
      WD   = '0;
      if (p_wr) begin
         RFWr = (p_rd != 5'd0);
         A3   = p_rd;
         WD   = p_wd;
      end else if (l_valid) begin
         RFWr = (l_rd != 5'd0);
         A3   = l_rd;
         WD   = l_wd;
      end
   end

   // pend_q[0] is held at zero, so x0 sources and destinations never hazard
   assign hazard_raw = (iss_use1 & pend_q[iss_rs1]) | (iss_use2 & pend_q[iss_rs2]);
   assign hazard_waw = iss_wr & pend_q[iss_rd];
   assign cap_full   = iss_long & (out_q == OW'(MAX_OUT));
   assign starved    = (starve_q >= SW'(STARVE_LIM));
   assign iss_stall  = iss_valid & (hazard_raw | hazard_waw | cap_full | starved);
   assign long_acc   = iss_valid & ~iss_stall & iss_long & iss_wr;

   always_comb begin
      pend_d = pend_q;
      if (long_grant) pend_d[l_rd] = 1'b0;
      if (long_acc && iss_rd != 5'd0) pend_d[iss_rd] = 1'b1;
      pend_d[0] = 1'b0;

      out_d = out_q;
      case ({long_acc, long_grant})
         2'b10:   if (out_q != OW'(MAX_OUT)) out_d = out_q + OW'(1);
         2'b01:   if (out_q != '0) out_d = out_q - OW'(1);
         default: out_d = out_q;
      endcase

      starve_d = starve_q;
      if (long_grant || !l_valid) starve_d = '0;
      else if (starve_q < SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q   <= '0;
         out_q    <= '0;
         starve_q <= '0;
      end else begin
         pend_q   <= pend_d;
         out_q    <= out_d;
         starve_q <= starve_d;
      end
   end

   assign pend        = pend_q;
   assign outstanding = out_q;

   // A long result with nothing outstanding means the long unit and decode disagree
   a_no_orphan_return: assert property (@(posedge clk) disable iff (rst)
      !(l_valid && out_q == '0));

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Bench for rf_wb_scoreboard: directed vector table for the corner cases, then
// randomized traffic compared against an in-flight-queue reference model.
module tb_rf_wb_scoreboard;
   localparam int MAX_OUT = 4;
   localparam int LIM     = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_use1, iss_use2, iss_wr, iss_long, iss_stall;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        p_wr, l_valid, l_ready, RFWr;
   logic [4:0]  p_rd, l_rd, A3;
   logic [31:0] p_wd, l_wd, WD, pend;
   logic [2:0]  outstanding;

   int n_total = 0;
   int n_pass  = 0;

   rf_wb_scoreboard #(.MAX_OUT(MAX_OUT), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
      .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_rd(iss_rd),
      .iss_wr(iss_wr), .iss_long(iss_long), .iss_stall(iss_stall),
      .p_wr(p_wr), .p_rd(p_rd), .p_wd(p_wd),
      .l_valid(l_valid), .l_rd(l_rd), .l_wd(l_wd), .l_ready(l_ready),
      .RFWr(RFWr), .A3(A3), .WD(WD), .pend(pend), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rd;
      logic        wr;
      logic        lng;
      logic        pw;
      logic [4:0]  prd;
      logic [31:0] pwd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] lwd;
      logic        e_stall;
      logic        e_lrdy;
      logic        e_rfwr;
      logic [4:0]  e_a3;
      logic [31:0] e_wd;
      logic [31:0] e_pend;
      logic [31:0] e_out;
   } vec_t;

   vec_t tbl[$];

   // reference model: the set of in-flight long destinations plus a starvation count
   logic [4:0] inflight[$];
   int starve_m;

   function automatic vec_t mk(int iv, int rs1, int u1, int rd, int wr, int lng,
                               int pw, int prd, int pwd, int lv, int lrd, int lwd,
                               int es, int elr, int erf, int ea3, int ewd, int epend, int eout);
      vec_t v;
      v.iv = 1'(iv);   v.rs1 = 5'(rs1); v.u1 = 1'(u1);   v.rd = 5'(rd);
      v.wr = 1'(wr);   v.lng = 1'(lng); v.pw = 1'(pw);   v.prd = 5'(prd);
      v.pwd = 32'(pwd); v.lv = 1'(lv);  v.lrd = 5'(lrd); v.lwd = 32'(lwd);
      v.e_stall = 1'(es); v.e_lrdy = 1'(elr); v.e_rfwr = 1'(erf);
      v.e_a3 = 5'(ea3); v.e_wd = 32'(ewd); v.e_pend = 32'(epend); v.e_out = 32'(eout);
      return v;
   endfunction

   function automatic logic m_pend(logic [4:0] r);
      if (r == 5'd0) return 1'b0;
      foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_pendvec();
      logic [31:0] p = '0;
      foreach (inflight[i]) if (inflight[i] != 5'd0) p[inflight[i]] = 1'b1;
      return p;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   task automatic idle_inputs();
      iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_use1 = 0; iss_use2 = 0;
      iss_rd = 0; iss_wr = 0; iss_long = 0;
      p_wr = 0; p_rd = 0; p_wd = 0; l_valid = 0; l_rd = 0; l_wd = 0;
   endtask

   task automatic run_vec(vec_t v, int idx);
      string s;
      idle_inputs();
      iss_valid = v.iv; iss_rs1 = v.rs1; iss_use1 = v.u1; iss_rd = v.rd;
      iss_wr = v.wr; iss_long = v.lng;
      p_wr = v.pw; p_rd = v.prd; p_wd = v.pwd;
      l_valid = v.lv; l_rd = v.lrd; l_wd = v.lwd;
      #3;
      s = $sformatf("row%0d", idx);
      chk({s, ".stall"}, 32'(iss_stall), 32'(v.e_stall));
      chk({s, ".l_ready"}, 32'(l_ready), 32'(v.e_lrdy));
      chk({s, ".RFWr"}, 32'(RFWr), 32'(v.e_rfwr));
      chk({s, ".A3"}, 32'(A3), 32'(v.e_a3));
      chk({s, ".WD"}, WD, v.e_wd);
      chk({s, ".pend"}, pend, v.e_pend);
      chk({s, ".outstanding"}, 32'(outstanding), v.e_out);
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      #2;
      iss_valid = 1; iss_use1 = 1; iss_rs1 = 5'd5;
      #1;
      chk("reset.pend", pend, 32'h0);
      chk("reset.outstanding", 32'(outstanding), 32'd0);
      chk("reset.stall", 32'(iss_stall), 32'd0);
      #9 rst = 1'b0;
      @(posedge clk);
      #1;

      // x5 long op, RAW stall, return and release
      tbl.push_back(mk(1,0,0,5,1,1, 0,0,0, 0,0,0,          0,0,0,0,0, 'h20*0,0));
      tbl.push_back(mk(1,5,1,0,0,0, 0,0,0, 0,0,0,          1,0,0,0,0, 'h20,1));
      tbl.push_back(mk(1,5,1,0,0,0, 0,0,0, 1,5,'hDEADBEEF, 1,1,1,5,'hDEADBEEF, 'h20,1));
      tbl.push_back(mk(1,5,1,0,0,0, 0,0,0, 0,0,0,          0,0,0,0,0, 0,0));
      // pipeline wins the write port, long write follows
      tbl.push_back(mk(1,0,0,7,1,1, 0,0,0,    0,0,0,     0,0,0,0,0,     0,0));
      tbl.push_back(mk(0,0,0,0,0,0, 1,3,'h11, 1,7,'h22,  0,0,1,3,'h11,  'h80,1));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,    1,7,'h22,  0,1,1,7,'h22,  'h80,1));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,    0,0,0,     0,0,0,0,0,     0,0));
      // fill to capacity
      for (int r = 1; r <= 4; r++)
         tbl.push_back(mk(1,0,0,r,1,1, 0,0,0, 0,0,0, 0,0,0,0,0, (1 << r) - 2, r - 1));
      tbl.push_back(mk(1,0,0,6,1,1, 0,0,0, 0,0,0,     1,0,0,0,0,    'h1E,4));
      tbl.push_back(mk(1,0,0,6,1,1, 0,0,0, 1,1,'hA,   1,1,1,1,'hA,  'h1E,4));
      tbl.push_back(mk(1,0,0,1,1,1, 0,0,0, 1,2,'hB,   0,1,1,2,'hB,  'h1C,3));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0, 0,0,0,     0,0,0,0,0,    'h1A,3));
      // starvation: eight denied cycles, throttle on the ninth
      for (int k = 0; k < 8; k++)
         tbl.push_back(mk(1,10,1,0,0,0, 1,9,'h99, 1,3,'h33, 0,0,1,9,'h99, 'h1A,3));
      tbl.push_back(mk(1,10,1,0,0,0, 1,9,'h99, 1,3,'h33, 1,0,1,9,'h99, 'h1A,3));
      tbl.push_back(mk(1,10,1,0,0,0, 0,0,0,    1,3,'h33, 1,1,1,3,'h33, 'h1A,3));
      tbl.push_back(mk(1,10,1,0,0,0, 0,0,0,    0,0,0,    0,0,0,0,0,    'h12,2));
      // long op to x0
      tbl.push_back(mk(1,0,0,0,1,1, 0,0,0, 0,0,0,     0,0,0,0,0,    'h12,2));
      tbl.push_back(mk(0,0,0,0,0,0, 0,0,0, 1,0,'h55,  0,1,0,0,'h55, 'h12,3));
      tbl.push_back(mk(1,0,1,0,0,0, 0,0,0, 0,0,0,     0,0,0,0,0,    'h12,2));
      // build up to pend=0x1E before the asynchronous reset
      tbl.push_back(mk(1,0,0,2,1,1, 0,0,0, 0,0,0,     0,0,0,0,0,    'h12,2));
      tbl.push_back(mk(1,0,0,3,1,1, 0,0,0, 0,0,0,     0,0,0,0,0,    'h16,3));

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // asynchronous reset between clock edges
      idle_inputs();
      iss_valid = 1; iss_use1 = 1; iss_rs1 = 5'd1;
      #2;
      chk("midrst.pre_stall", 32'(iss_stall), 32'd1);
      chk("midrst.pre_pend", pend, 32'h1E);
      chk("midrst.pre_out", 32'(outstanding), 32'd4);
      rst = 1'b1;
      #1;
      chk("midrst.pend", pend, 32'h0);
      chk("midrst.outstanding", 32'(outstanding), 32'd0);
      chk("midrst.stall", 32'(iss_stall), 32'd0);
      @(posedge clk);
      #3 rst = 1'b0;
      inflight.delete();
      starve_m = 0;
      @(posedge clk);
      #1;

      // randomized traffic against the reference model
      for (int c = 0; c < 3000; c++) begin
         int li;
         int pw_pct;
         logic e_stall, e_lrdy, e_rfwr;
         logic [4:0] e_a3;
         logic [31:0] e_wd;
         pw_pct = ((c / 60) % 2 == 0) ? 90 : 35;
         iss_valid = ($urandom_range(0, 99) < 70);
         iss_rs1 = 5'($urandom_range(0, 7));
         iss_rs2 = 5'($urandom_range(0, 7));
         iss_rd  = 5'($urandom_range(0, 7));
         iss_use1 = 1'($urandom);
         iss_use2 = 1'($urandom);
         iss_wr   = 1'($urandom);
         iss_long = iss_wr && ($urandom_range(0, 2) == 0);
         p_wr = ($urandom_range(0, 99) < pw_pct);
         p_rd = 5'($urandom);
         p_wd = $urandom;
         li = 0;
         l_valid = 0; l_rd = 0; l_wd = $urandom;
         if (inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
            li = $urandom_range(0, inflight.size() - 1);
            l_valid = 1;
            l_rd = inflight[li];
         end

         e_lrdy = l_valid && !p_wr;
         e_rfwr = p_wr ? (p_rd != 0) : (l_valid ? (l_rd != 0) : 1'b0);
         e_a3   = p_wr ? p_rd : (l_valid ? l_rd : 5'd0);
         e_wd   = p_wr ? p_wd : (l_valid ? l_wd : 32'd0);
         e_stall = iss_valid && ((iss_use1 && m_pend(iss_rs1)) || (iss_use2 && m_pend(iss_rs2)) ||
                   (iss_wr && m_pend(iss_rd)) || (iss_long && inflight.size() == MAX_OUT) ||
                   (starve_m >= LIM));
         #3;
         chk("rnd.stall", 32'(iss_stall), 32'(e_stall));
         chk("rnd.l_ready", 32'(l_ready), 32'(e_lrdy));
         chk("rnd.RFWr", 32'(RFWr), 32'(e_rfwr));
         chk("rnd.A3", 32'(A3), 32'(e_a3));
         chk("rnd.WD", WD, e_wd);
         chk("rnd.pend", pend, m_pendvec());
         chk("rnd.outstanding", 32'(outstanding), 32'(inflight.size()));
         @(posedge clk);
         if (e_lrdy) begin
            inflight.delete(li);
            starve_m = 0;
         end else if (l_valid) begin
            starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
         end else begin
            starve_m = 0;
         end
         if (iss_valid && !e_stall && iss_long && iss_wr) inflight.push_back(iss_rd);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
